oam_dma_arbiter: RTL and testbench



---
 rtl/gb_mem_pkg.sv | 23 ++
 rtl/oam_dma_arbiter.sv | 114 +++++++++++
 tb/tb_oam_dma_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants, DMA state encoding and address helpers
// for the Game Boy memory path.
package gb_mem_pkg;

  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam logic [15:0] DMA_REG  = 16'hFF46;
  localparam logic [15:0] HRAM_LO  = 16'hFF80;
  localparam logic [15:0] HRAM_HI  = 16'hFFFE;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    RD,
    CAP,
    WR,
    SLOT
  } dma_state_t;

  function automatic logic isHram(input logic [15:0] addr);
    return (addr >= HRAM_LO) && (addr <= HRAM_HI);
  endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine: owns the 0xFF46 register, copies DMA_LEN bytes into OAM
// and time-slices the mmu port with the CPU while the copy runs.
module oam_dma_arbiter #(
  parameter logic [15:0] OAM_BASE    = gb_mem_pkg::OAM_BASE,
  parameter int unsigned DMA_LEN     = 160,
  parameter logic [15:0] DMA_REG     = gb_mem_pkg::DMA_REG,
  parameter int unsigned START_DELAY = 4
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oCpuData,
  output logic        oCpuWait,
  output logic [15:0] oMmuAddr,
  output logic        oMmuWe,
  output logic [7:0]  oMmuData,
  input  logic [7:0]  iMmuData,
  output logic        oDmaActive
);
  import gb_mem_pkg::*;

  localparam int unsigned   DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(START_DELAY - 1);
  localparam logic [8:0]    LEN      = 9'(DMA_LEN);

  dma_state_t       state;
  logic [7:0]       rSrc;
  logic [7:0]       rByte;
  logic [8:0]       rCount;
  logic [DLY_W-1:0] dly;

  logic [7:0] src_hi;
  logic [8:0] cnt_nxt;
  logic       cpu_reg;
  logic       cpu_hram;
  logic       reg_wr;
  logic       engine;
  logic       blocked;

  // Sources in 0xE0..0xFF are echo RAM and fold back onto work RAM.
  assign src_hi   = (rSrc < 8'hE0) ? rSrc : (rSrc - 8'h20);
  assign cnt_nxt  = rCount + 9'd1;
  assign cpu_reg  = (iCpuAddr == DMA_REG);
  assign cpu_hram = isHram(iCpuAddr);
  assign reg_wr   = cpu_reg && iCpuWe;
  assign engine   = (state == RD) || (state == CAP) || (state == WR);
  assign blocked  = (state != IDLE) && (state != DELAY) && !cpu_hram && !cpu_reg;

  assign oDmaActive = (state != IDLE);

  // A register write restarts the copy from any state and beats every other move.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state  <= IDLE;
      rSrc   <= 8'h00;
      rCount <= 9'd0;
      rByte  <= 8'h00;
      dly    <= '0;
    end else if (reg_wr) begin
      rSrc   <= iCpuData;
      rCount <= 9'd0;
      dly    <= DLY_INIT;
      state  <= DELAY;
    end else begin
      case (state)
        DELAY: begin
          if (dly == '0) state <= RD;
          else           dly   <= dly - DLY_W'(1);
        end
        RD:  state <= CAP;
        CAP: begin
          rByte <= iMmuData;
          state <= WR;
        end
        WR:  state <= SLOT;
        SLOT: begin
          rCount <= cnt_nxt;
          state  <= (cnt_nxt == LEN) ? IDLE : RD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    oMmuAddr = iCpuAddr;
    oMmuWe   = iCpuWe;
    oMmuData = iCpuData;
    oCpuData = iMmuData;
    oCpuWait = 1'b0;
    if (engine) begin
      oMmuAddr = (state == WR) ? (OAM_BASE + {7'b0, rCount}) : {src_hi, rCount[7:0]};
      oMmuWe   = (state == WR);
      oMmuData = rByte;
      oCpuData = 8'hFF;
      oCpuWait = cpu_hram;
    end else if (blocked) begin
      oMmuWe   = 1'b0;
      oCpuData = 8'hFF;
    end
    // The DMA register lives here; the mmu never sees its address.
    if (cpu_reg) begin
      oCpuData = rSrc;
      oCpuWait = 1'b0;
      if (!engine) begin
        oMmuAddr = 16'h0000;
        oMmuWe   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: byte-wide memory model on the mmu port and a
// scoreboard of expected mmu writes.
module tb_oam_dma_arbiter;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic        iCpuWe;
  logic [7:0]  iCpuData;
  logic [7:0]  oCpuData;
  logic        oCpuWait;
  logic [15:0] oMmuAddr;
  logic        oMmuWe;
  logic [7:0]  oMmuData;
  logic [7:0]  iMmuData;
  logic        oDmaActive;

  oam_dma_arbiter dut (
    .iClock(iClock), .iReset(iReset),
    .iCpuAddr(iCpuAddr), .iCpuWe(iCpuWe), .iCpuData(iCpuData),
    .oCpuData(oCpuData), .oCpuWait(oCpuWait),
    .oMmuAddr(oMmuAddr), .oMmuWe(oMmuWe), .oMmuData(oMmuData),
    .iMmuData(iMmuData), .oDmaActive(oDmaActive)
  );

  always #5 iClock = ~iClock;

  // mmu model: one-clock read latency; page fill port for preloading
  logic [7:0] mem [0:65535];
  logic [7:0] mmu_rd;
  logic       pl_fill = 1'b0;
  logic [7:0] pl_page = 8'h00;
  logic [7:0] pl_key  = 8'h00;
  assign iMmuData = mmu_rd;

  always @(posedge iClock) begin
    if (pl_fill) begin
      for (int k = 0; k < 256; k++) mem[{pl_page, k[7:0]}] <= k[7:0] ^ pl_key;
    end else if (oMmuWe) begin
      mem[oMmuAddr] <= oMmuData;
    end
    mmu_rd <= mem[oMmuAddr];
  end

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [23:0] exp_q[$];

  // every mmu write must match one outstanding expectation
  always @(negedge iClock) begin
    if (!iReset && oMmuWe === 1'b1) begin
      automatic logic found = 1'b0;
      wr_cnt++;
      total++;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i] == {oMmuAddr, oMmuData}) begin
          exp_q.delete(i);
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        bad++;
        $display("FAIL mmu_write: got addr=%h data=%h, no such write expected", oMmuAddr, oMmuData);
      end
    end
  end

  task automatic tick;
    @(posedge iClock);
    #1;
  endtask

  task automatic idle_bus;
    iCpuAddr = 16'h0000;
    iCpuWe   = 1'b0;
    iCpuData = 8'h00;
  endtask

  task automatic fill(input logic [7:0] page, input logic [7:0] key);
    pl_page = page;
    pl_key  = key;
    pl_fill = 1'b1;
    tick();
    pl_fill = 1'b0;
  endtask

  task automatic push_copy(input logic [7:0] key, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({16'hFE00 + 16'(k), 8'(k) ^ key});
  endtask

  task automatic reg_write(input logic [7:0] d);
    iCpuAddr = 16'hFF46;
    iCpuWe   = 1'b1;
    iCpuData = d;
    tick();
    idle_bus();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (oDmaActive === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (oDmaActive !== 1'b0) begin
      bad++;
      $display("FAIL %s: active=%b after %0d clocks, need 0", name, oDmaActive, n);
    end
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n = 0;
    while (wr_cnt < target && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (wr_cnt != target) begin
      bad++;
      $display("FAIL %s: writes=%0d, need %0d", name, wr_cnt, target);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected writes never seen", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_page(input int lo, input int hi, input logic [7:0] key, input string name);
    int errs = 0;
    int first = -1;
    for (int k = lo; k <= hi; k++) begin
      if (mem[16'hFE00 + 16'(k)] !== (8'(k) ^ key)) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: %0d bad OAM bytes, first k=%0d got %h need %h", name, errs, first,
               mem[16'hFE00 + 16'(first)], 8'(first) ^ key);
    end
  endtask

  task automatic test_reset;
    idle_bus();
    iReset = 1'b1;
    repeat (2) tick();
    iReset = 1'b0;
    total++;
    if (oDmaActive !== 1'b0 || oMmuWe !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: active=%b we=%b, need 0/0", oDmaActive, oMmuWe);
    end
    iCpuAddr = 16'hFF46;
    #1;
    total++;
    if (oCpuData !== 8'h00 || oCpuWait !== 1'b0) begin
      bad++;
      $display("FAIL reset_reg: data=%h wait=%b, need 00/0", oCpuData, oCpuWait);
    end
    idle_bus();
  endtask

  task automatic test_idle_passthrough;
    iCpuAddr = 16'h8123; iCpuWe = 1'b1; iCpuData = 8'h77;
    exp_q.push_back({16'h8123, 8'h77});
    #1;
    total++;
    if (oCpuWait !== 1'b0) begin
      bad++; $display("FAIL idle_wr_wait: wait=%b need 0", oCpuWait);
    end
    tick();
    iCpuWe = 1'b0;
    #1;
    total++;
    if (oCpuWait !== 1'b0) begin
      bad++; $display("FAIL idle_rd_wait: wait=%b need 0", oCpuWait);
    end
    tick();
    total++;
    if (oCpuData !== 8'h77) begin
      bad++; $display("FAIL idle_rd_data: got %h need 77", oCpuData);
    end
    idle_bus();
    check_drained("idle_sb");
  endtask

  task automatic test_basic_copy;
    fill(8'hC1, 8'h5A);
    wr_cnt = 0;
    push_copy(8'h5A, 160);
    reg_write(8'hC1);
    for (int c = 1; c <= 700; c++) begin
      tick();
      if (c == 3) begin
        total++;
        if (oMmuAddr !== 16'h0000) begin
          bad++; $display("FAIL early_rd: addr=%h at clock 3, need 0000", oMmuAddr);
        end
      end
      if (c == 4) begin
        total++;
        if (oMmuAddr !== 16'hC100 || oMmuWe !== 1'b0) begin
          bad++; $display("FAIL first_rd: addr=%h we=%b, need C100/0", oMmuAddr, oMmuWe);
        end
      end
      if (c == 643) begin
        total++;
        if (oDmaActive !== 1'b1) begin
          bad++; $display("FAIL active_643: got %b need 1", oDmaActive);
        end
      end
      if (c == 644) begin
        total++;
        if (oDmaActive !== 1'b0) begin
          bad++; $display("FAIL active_644: got %b need 0", oDmaActive);
        end
        break;
      end
    end
    total++;
    if (wr_cnt != 160) begin
      bad++; $display("FAIL basic_count: writes=%0d need 160", wr_cnt);
    end
    check_page(0, 159, 8'h5A, "basic_oam");
    check_drained("basic_sb");
  endtask

  task automatic test_blocking;
    fill(8'h80, 8'h11);
    wr_cnt = 0;
    push_copy(8'h5A, 160);
    reg_write(8'hC1);
    for (int c = 1; c <= 20; c++) begin
      tick();
      idle_bus();
      if (c == 9 || c == 11) begin
        iCpuAddr = 16'hC000;
        #1;
        total++;
        if (oCpuData !== 8'hFF || oCpuWait !== 1'b0) begin
          bad++; $display("FAIL block_rd c=%0d: data=%h wait=%b, need FF/0", c, oCpuData, oCpuWait);
        end
      end else if (c >= 12 && c <= 15) begin
        iCpuAddr = 16'h8000; iCpuWe = 1'b1; iCpuData = 8'h99;
        #1;
        total++;
        if (oCpuWait !== 1'b0) begin
          bad++; $display("FAIL block_wr c=%0d: wait=%b need 0", c, oCpuWait);
        end
      end else if (c >= 16 && c <= 19) begin
        iCpuAddr = 16'hFF90; iCpuWe = 1'b1; iCpuData = 8'h42;
        #1;
        total++;
        if (oCpuWait !== (c < 19)) begin
          bad++; $display("FAIL hram_wait c=%0d: wait=%b need %b", c, oCpuWait, c < 19);
        end
        if (c == 19) exp_q.push_back({16'hFF90, 8'h42});
      end
    end
    wait_idle(700, "block_done");
    total++;
    if (wr_cnt != 161) begin
      bad++; $display("FAIL block_count: writes=%0d need 161", wr_cnt);
    end
    total++;
    if (mem[16'h8000] !== 8'h11 || mem[16'hFF90] !== 8'h42) begin
      bad++; $display("FAIL block_mem: 8000=%h FF90=%h, need 11/42", mem[16'h8000], mem[16'hFF90]);
    end
    check_drained("block_sb");
  endtask

  task automatic test_restart;
    fill(8'hC2, 8'hA5);
    wr_cnt = 0;
    push_copy(8'h5A, 50);
    reg_write(8'hC1);
    wait_writes(50, 400, "restart_pre");
    push_copy(8'hA5, 160);
    wr_cnt = 0;
    reg_write(8'hC2);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin
        total++;
        if (oMmuAddr !== 16'hC200 || oMmuWe !== 1'b0) begin
          bad++; $display("FAIL restart_rd: addr=%h we=%b, need C200/0", oMmuAddr, oMmuWe);
        end
      end
    end
    wait_writes(160, 700, "restart_160");
    // now in the CPU slot after byte 159; the register write must win
    push_copy(8'h5A, 160);
    wr_cnt = 0;
    reg_write(8'hC1);
    total++;
    if (oDmaActive !== 1'b1) begin
      bad++; $display("FAIL restart_wins: active=%b need 1", oDmaActive);
    end
    wait_idle(700, "restart_done");
    total++;
    if (wr_cnt != 160) begin
      bad++; $display("FAIL restart_count: writes=%0d need 160", wr_cnt);
    end
    check_drained("restart_sb");
  endtask

  task automatic test_echo;
    fill(8'hC3, 8'h3C);
    wr_cnt = 0;
    push_copy(8'h3C, 160);
    reg_write(8'hE3);
    iCpuAddr = 16'hFF46;
    #1;
    total++;
    if (oCpuData !== 8'hE3 || oCpuWait !== 1'b0) begin
      bad++; $display("FAIL echo_reg: data=%h wait=%b, need E3/0", oCpuData, oCpuWait);
    end
    idle_bus();
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin
        total++;
        if (oMmuAddr !== 16'hC300) begin
          bad++; $display("FAIL echo_rd: addr=%h need C300", oMmuAddr);
        end
      end
    end
    wait_idle(700, "echo_done");
    check_page(0, 159, 8'h3C, "echo_oam");
    check_drained("echo_sb");
  endtask

  task automatic test_reset_mid;
    fill(8'hFE, 8'hEE);
    fill(8'hC1, 8'h5A);
    wr_cnt = 0;
    push_copy(8'h5A, 20);
    reg_write(8'hC1);
    wait_writes(20, 200, "rst_pre");
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    total++;
    if (oDmaActive !== 1'b0 || oMmuWe !== 1'b0) begin
      bad++; $display("FAIL rst_mid_out: active=%b we=%b, need 0/0", oDmaActive, oMmuWe);
    end
    repeat (30) tick();
    check_page(0, 19, 8'h5A, "rst_head");
    check_page(20, 159, 8'hEE, "rst_tail");
    iCpuAddr = 16'hFF46;
    #1;
    total++;
    if (oCpuData !== 8'h00) begin
      bad++; $display("FAIL rst_reg: got %h need 00", oCpuData);
    end
    idle_bus();
    check_drained("rst_sb");
  endtask

  initial begin
    iReset = 1'b1;
    idle_bus();
    test_reset();
    test_idle_passthrough();
    test_basic_copy();
    test_blocking();
    test_restart();
    test_echo();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
